// File: rtl/pipe_skid_fifo.sv
// N-entry valid/ready pipeline buffer with a registered upstream ready,
// fill-level reporting, an almost-full flag and a synchronous flush.
module pipe_skid_fifo #(
   parameter int DWIDTH       = 8,
   parameter int DEPTH        = 4,
   parameter int AFULL_THRESH = DEPTH - 1
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       i_flush,
   input  logic [DWIDTH-1:0]          i_data,
   input  logic                       i_valid,
   output logic                       o_ready,
   output logic [DWIDTH-1:0]          o_data,
   output logic                       o_valid,
   input  logic                       i_ready,
   output logic [$clog2(DEPTH):0]     o_count,
   output logic                       o_almost_full
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [DWIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]     r_wr_ptr;
   logic [PW-1:0]     r_rd_ptr;
   logic [CW-1:0]     r_count;
   logic              r_ready;
   logic              r_afull;

   logic              w_push;
   logic              w_pop;
   logic [CW-1:0]     w_count_next;

   assign w_push = i_valid & r_ready;
   assign w_pop  = (r_count != '0) & i_ready;

   // Flush wins over any handshake in the same cycle.
   always_comb begin
      w_count_next = r_count;
      if (i_flush) begin
         w_count_next = '0;
      end else begin
         case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + CW'(1);
            2'b01:   w_count_next = r_count - CW'(1);
            default: w_count_next = r_count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_ready  <= 1'b0;
         r_afull  <= 1'b0;
      end else begin
         if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
         end else begin
            if (w_push) begin
               r_mem[r_wr_ptr] <= i_data;
               r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
               r_rd_ptr <= r_rd_ptr + PW'(1);
            end
         end
         r_count <= w_count_next;
         // Ready and almost-full look at the next count so there is no bubble.
         r_ready <= (w_count_next < CW'(DEPTH));
         r_afull <= (w_count_next >= CW'(AFULL_THRESH));
      end
   end

   assign o_ready       = r_ready;
   assign o_valid       = (r_count != '0);
   assign o_data        = r_mem[r_rd_ptr];
   assign o_count       = r_count;
   assign o_almost_full = r_afull;

endmodule
